// File: rtl/exp1_pkg.sv
// Shared encodings and the output bundle for the exp1 gate/boolean-function block.
package exp1_pkg;

    localparam logic       TASK_GATE = 1'b0;
    localparam logic       TASK_FUNC = 1'b1;

    localparam logic [1:0] SUB_00 = 2'b00;
    localparam logic [1:0] SUB_01 = 2'b01;
    localparam logic [1:0] SUB_10 = 2'b10;
    localparam logic [1:0] SUB_11 = 2'b11;

    typedef struct packed {
        logic l1;
        logic l2;
        logic x;
        logic y;
        logic z;
    } out_t;

endpackage

// File: rtl/exp1_logic_core.sv
// Combinational function table: (task, subtask, a, b, c) -> lamp and result bits.
module exp1_logic_core
    import exp1_pkg::*;
(
    input  logic       mode_task,
    input  logic [1:0] mode_subtask,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output out_t       res
);

    logic maj;
    logic par;

    assign maj = (a & b) | (a & c) | (b & c);
    assign par = a ^ b ^ c;

    always_comb begin
        res = '0;
        case ({mode_task, mode_subtask})
            {TASK_GATE, SUB_00}: begin res.l1 = a & b;  res.l2 = ~(a & b); end
            {TASK_GATE, SUB_01}: begin res.l1 = a | b;  res.l2 = ~(a | b); end
            {TASK_GATE, SUB_10}: begin res.l1 = a ^ b;  res.l2 = ~(a ^ b); end
            {TASK_GATE, SUB_11}: begin res.l1 = ~a;     res.l2 = a;        end
            {TASK_FUNC, SUB_00}: begin
                res.x = a & b & c;
                res.y = a | b | c;
                res.z = par;
            end
            {TASK_FUNC, SUB_01}: begin
                res.x = par;
                res.y = maj;
            end
            {TASK_FUNC, SUB_10}: begin
                res.x = ~(a & b & c);
                res.y = ~a | ~b | ~c;
                res.z = ~((~(a & b & c)) ^ (~a | ~b | ~c));
            end
            {TASK_FUNC, SUB_11}: begin
                res.x = maj;
                res.y = a ? b : c;
                res.z = ~par;
            end
            // Unknown mode bits in simulation fall through to all-zero lamps.
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/exp1.sv
// exp1 top: registers the core's result for the board LEDs, one-cycle latency, sync reset.
module exp1
    import exp1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_task,
    input  logic [1:0] mode_subtask,
    input  logic       signal_a,
    input  logic       signal_b,
    input  logic       signal_c,
    output logic       signal_l1,
    output logic       signal_l2,
    output logic       signal_x,
    output logic       signal_y,
    output logic       signal_z
);

    out_t out_d;
    out_t out_q;

    exp1_logic_core u_core (
        .mode_task    (mode_task),
        .mode_subtask (mode_subtask),
        .a            (signal_a),
        .b            (signal_b),
        .c            (signal_c),
        .res          (out_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign signal_l1 = out_q.l1;
    assign signal_l2 = out_q.l2;
    assign signal_x  = out_q.x;
    assign signal_y  = out_q.y;
    assign signal_z  = out_q.z;

endmodule

// File: tb/tb_exp1.sv
// Self-checking bench for exp1: fixed vector table, reference-model sweeps, random vectors, corner sequences.
`timescale 1ns/1ps
module tb_exp1;

    logic       clk;
    logic       rst;
    logic       mode_task;
    logic [1:0] mode_subtask;
    logic       signal_a, signal_b, signal_c;
    logic       signal_l1, signal_l2, signal_x, signal_y, signal_z;

    int checks = 0;
    int errors = 0;

    exp1 dut (
        .clk          (clk),
        .rst          (rst),
        .mode_task    (mode_task),
        .mode_subtask (mode_subtask),
        .signal_a     (signal_a),
        .signal_b     (signal_b),
        .signal_c     (signal_c),
        .signal_l1    (signal_l1),
        .signal_l2    (signal_l2),
        .signal_x     (signal_x),
        .signal_y     (signal_y),
        .signal_z     (signal_z)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        logic       t;
        logic [1:0] s;
        logic [2:0] abc;
        logic [4:0] exp;   // {l1,l2,x,y,z}
    } vec_t;

    vec_t vecs[$];

    // Reference computed arithmetically from the function definitions.
    function automatic logic [4:0] model(input logic t, input logic [1:0] s, input logic [2:0] abc);
        int a, b, c, sum, l1, l2, x, y, z;
        a = int'(abc[2]); b = int'(abc[1]); c = int'(abc[0]);
        sum = a + b + c;
        l1 = 0; l2 = 0; x = 0; y = 0; z = 0;
        if (t == 1'b0) begin
            case (s)
                2'd0: l1 = a * b;
                2'd1: l1 = (a + b > 0) ? 1 : 0;
                2'd2: l1 = (a + b) % 2;
                default: l1 = 1 - a;
            endcase
            l2 = 1 - l1;
        end else begin
            case (s)
                2'd0: begin x = (sum == 3) ? 1 : 0; y = (sum > 0) ? 1 : 0; z = sum % 2; end
                2'd1: begin x = sum % 2; y = sum / 2; z = 0; end
                2'd2: begin x = (sum == 3) ? 0 : 1; y = x; z = 1; end
                default: begin
                    x = (sum >= 2) ? 1 : 0;
                    y = (a == 1) ? b : c;
                    z = 1 - (sum % 2);
                end
            endcase
        end
        return {l1[0], l2[0], x[0], y[0], z[0]};
    endfunction

    function automatic logic [4:0] got();
        return {signal_l1, signal_l2, signal_x, signal_y, signal_z};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got l1l2xyz=%b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic t, input logic [1:0] s, input logic [2:0] abc);
        @(negedge clk);
        mode_task = t; mode_subtask = s;
        {signal_a, signal_b, signal_c} = abc;
    endtask

    // Drive at negedge, let one rising edge capture, sample 1 ns later.
    task automatic apply_check(input string name, input logic t, input logic [1:0] s,
                               input logic [2:0] abc, input logic [4:0] exp);
        drive(t, s, abc);
        @(posedge clk); #1;
        check(name, got(), exp);
    endtask

    initial begin
        vecs.push_back('{1'b0, 2'b00, 3'b110, 5'b10000});
        vecs.push_back('{1'b0, 2'b01, 3'b000, 5'b01000});
        vecs.push_back('{1'b0, 2'b10, 3'b101, 5'b10000});
        vecs.push_back('{1'b0, 2'b11, 3'b100, 5'b01000});
        vecs.push_back('{1'b0, 2'b11, 3'b011, 5'b10000});
        vecs.push_back('{1'b1, 2'b00, 3'b111, 5'b00111});
        vecs.push_back('{1'b1, 2'b01, 3'b101, 5'b00010});
        vecs.push_back('{1'b1, 2'b01, 3'b111, 5'b00110});
        vecs.push_back('{1'b1, 2'b01, 3'b000, 5'b00000});
        vecs.push_back('{1'b1, 2'b10, 3'b101, 5'b00111});
        vecs.push_back('{1'b1, 2'b11, 3'b011, 5'b00111});
        vecs.push_back('{1'b1, 2'b11, 3'b100, 5'b00000});

        rst = 1'b1; mode_task = 1'b1; mode_subtask = 2'b00;
        signal_a = 1'b1; signal_b = 1'b1; signal_c = 1'b1;

        // Reset held two cycles with all operands high.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("reset_hold", got(), 5'b00000);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("reset_release", got(), 5'b00111);

        foreach (vecs[i])
            apply_check($sformatf("table[%0d]", i), vecs[i].t, vecs[i].s, vecs[i].abc, vecs[i].exp);

        // Exhaustive sweep of both tasks against the model.
        for (int t = 0; t < 2; t++)
            for (int s = 0; s < 4; s++)
                for (int v = 0; v < 8; v++)
                    apply_check($sformatf("sweep t%0d s%0d abc%0d", t, s, v), t[0], s[1:0], v[2:0],
                                model(t[0], s[1:0], v[2:0]));

        // Task 0 -> 1 switch between edges: old result holds until the next edge.
        apply_check("switch_pre", 1'b0, 2'b00, 3'b110, 5'b10000);
        drive(1'b1, 2'b00, 3'b110);
        check("switch_hold", got(), 5'b10000);
        @(posedge clk); #1;
        check("switch_post", got(), 5'b00010);

        // Reset wins over a mode change in the same cycle.
        @(negedge clk);
        rst = 1'b1; mode_task = 1'b0; mode_subtask = 2'b11; signal_a = 1'b0;
        @(posedge clk); #1;
        check("reset_priority", got(), 5'b00000);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("reset_priority_release", got(), 5'b10000);

        // Randomized vectors, occasionally asserting reset.
        for (int i = 0; i < 300; i++) begin
            logic       t, r;
            logic [1:0] s;
            logic [2:0] abc;
            t = 1'($urandom_range(1, 0));
            s = 2'($urandom_range(3, 0));
            abc = 3'($urandom_range(7, 0));
            r = ($urandom_range(15, 0) == 0);
            @(negedge clk);
            rst = r; mode_task = t; mode_subtask = s;
            {signal_a, signal_b, signal_c} = abc;
            @(posedge clk); #1;
            check($sformatf("random[%0d]", i), got(), r ? 5'b00000 : model(t, s, abc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
